// File: rtl/bomb_game_ctrl.sv
// bomb_game_ctrl: game sequencer for the bomb-defusal dot-matrix display.
// Arms the bomb, runs the fuse prescaler, draws a secret wire from a
// free-running LFSR and judges wire cuts. Ends in DEFUSED or EXPLODED.
// Optional feature macro: BOMB_CUT_PENALTY_EN
//   undefined -> a wrong cut explodes the bomb at once
//   defined   -> a wrong cut burns one extra fuse step instead
module bomb_game_ctrl #(
   parameter int         TICK_DIV   = 50,
   parameter int         FUSE_STEPS = 4,
   parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       power,
   input  logic       arm,
   input  logic [3:0] cut,
   output logic       bomb_en,
   output logic       start,
   output logic [2:0] fuse_level,
   output logic       fail,
   output logic       win,
   output logic [1:0] state
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] ARMED    = 2'd1;
   localparam logic [1:0] DEFUSED  = 2'd2;
   localparam logic [1:0] EXPLODED = 2'd3;

   localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
   localparam logic [2:0]    LEVEL_MAX = 3'(FUSE_STEPS);

   logic [1:0]    state_reg, state_next;
   logic [2:0]    level_reg, level_next;
   logic [PW-1:0] pre_reg, pre_next;
   logic [1:0]    key_reg, key_next;
   logic [7:0]    lfsr_reg;
   logic          arm_q;
   logic [3:0]    cut_q;
   logic          arm_rise;
   logic [3:0]    cut_rise;
   logic [3:0]    key_mask;
   logic          wrong_cut;
   logic          right_cut;
   logic          tick;

   assign arm_rise = arm & ~arm_q;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_cut_edge
         assign cut_rise[gi] = cut[gi] & ~cut_q[gi];
      end
   endgenerate

   assign key_mask  = 4'b0001 << key_reg;
   assign wrong_cut = |(cut_rise & ~key_mask);
   assign right_cut = |(cut_rise & key_mask);
   assign tick      = (pre_reg == PRE_LAST);

   assign state      = state_reg;
   assign fuse_level = level_reg;

   // Next-state decision: power loss first, then arming, then cut/tick judging while ARMED.
   always_comb begin
      state_next = state_reg;
      level_next = level_reg;
      pre_next   = pre_reg;
      key_next   = key_reg;
      if (!power) begin
         state_next = IDLE;
         level_next = '0;
         pre_next   = '0;
         key_next   = '0;
      end else if (state_reg != ARMED) begin
         if (arm_rise && (cut == 4'b0000)) begin
            state_next = ARMED;
            level_next = '0;
            pre_next   = '0;
            key_next   = lfsr_reg[1:0];
         end
      end else if (wrong_cut) begin
`ifdef BOMB_CUT_PENALTY_EN
         // Penalty step also swallows a tick landing on the same cycle.
         pre_next   = '0;
         level_next = level_reg + 3'd1;
         if (level_next >= LEVEL_MAX) begin
            level_next = LEVEL_MAX;
            state_next = EXPLODED;
         end
`else
         state_next = EXPLODED;
         level_next = LEVEL_MAX;
`endif
      end else if (right_cut) begin
         state_next = DEFUSED;
      end else if (tick) begin
         pre_next   = '0;
         level_next = level_reg + 3'd1;
         if (level_next >= LEVEL_MAX) begin
            level_next = LEVEL_MAX;
            state_next = EXPLODED;
         end
      end else begin
         pre_next = pre_reg + PW'(1);
      end
   end

   // State, LFSR, edge history and registered flag outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         level_reg <= '0;
         pre_reg   <= '0;
         key_reg   <= '0;
         lfsr_reg  <= LFSR_SEED;
         arm_q     <= 1'b1;
         cut_q     <= 4'b1111;
         bomb_en   <= 1'b0;
         start     <= 1'b0;
         fail      <= 1'b0;
         win       <= 1'b0;
      end else begin
         state_reg <= state_next;
         level_reg <= level_next;
         pre_reg   <= pre_next;
         key_reg   <= key_next;
         lfsr_reg  <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
         arm_q     <= arm;
         cut_q     <= cut;
         bomb_en   <= power;
         start     <= (state_next == ARMED);
         fail      <= (state_next == EXPLODED);
         win       <= (state_next == DEFUSED);
      end
   end

endmodule
